// File: rtl/uart_frame_tx.sv
// UART report transmitter: queues multi-byte status words in a small frame FIFO and
// sends each one MSB-byte first as 8-bit characters with optional parity and terminator.
module uart_frame_tx #(
  parameter int          BAUD_DIV  = 434,
  parameter int          NBYTES    = 2,
  parameter int          DEPTH     = 4,
  parameter int          PARITY    = 0,
  parameter int          TERM_EN   = 1,
  parameter logic [7:0]  TERM_BYTE = 8'h0A
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [8*NBYTES-1:0]   i_data,
  input  logic                  wr,
  output logic                  s_out,
  output logic                  busy,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int   PTR_W   = $clog2(DEPTH);
  localparam int   CNT_W   = PTR_W + 1;
  localparam int   BAUD_W  = $clog2(BAUD_DIV);
  localparam int   NCHAR   = NBYTES + TERM_EN;
  localparam int   BIDX_W  = $clog2(NCHAR + 1);
  localparam int   FRAME_W = 8 * NBYTES;
  localparam logic PAR_EN  = (PARITY != 32'sd0);
  localparam logic PAR_ODD = (PARITY == 32'sd2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t               state_r, state_nx_s;
  logic [FRAME_W-1:0]   fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r, count_nx_s;
  logic                 push_s, pop_s;
  logic [FRAME_W-1:0]   frame_r;
  logic [BIDX_W-1:0]    byte_idx_r;
  logic [2:0]           bit_idx_r, bit_idx_nx_s;
  logic [BAUD_W-1:0]    baud_cnt_r;
  logic                 bit_tick_s, last_byte_s, advance_s;
  logic [7:0]           cur_byte_s;
  logic                 line_nx_s;
  logic                 s_out_r, busy_r, empty_r, full_r, overflow_r;

  function automatic logic parity_of(input logic [7:0] b);
    return (^b) ^ PAR_ODD;
  endfunction

  // full is the registered flag, so a write in the same cycle as a pop from a full FIFO is refused
  assign push_s      = wr & ~full_r;
  assign pop_s       = (state_r == S_LOAD);
  assign bit_tick_s  = (baud_cnt_r == BAUD_W'(BAUD_DIV - 1));
  assign last_byte_s = (byte_idx_r == BIDX_W'(NCHAR - 1));
  assign advance_s   = (state_r == S_STOP) & bit_tick_s & ~last_byte_s;
  assign cur_byte_s  = (byte_idx_r >= BIDX_W'(NBYTES)) ? TERM_BYTE : frame_r[FRAME_W-1 -: 8];

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_nx_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CNT_W'(1);
      2'b01:   count_nx_s = count_r - CNT_W'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // FIFO storage (no reset needed; validity tracked by count)
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  if (!empty_r) state_nx_s = S_LOAD; else state_nx_s = S_IDLE;
      S_LOAD:  state_nx_s = S_START;
      S_START: if (bit_tick_s) state_nx_s = S_DATA; else state_nx_s = S_START;
      S_DATA: begin
        if (bit_tick_s && (bit_idx_r == 3'd7)) begin
          if (PAR_EN) state_nx_s = S_PAR; else state_nx_s = S_STOP;
        end else begin
          state_nx_s = S_DATA;
        end
      end
      S_PAR:   if (bit_tick_s) state_nx_s = S_STOP; else state_nx_s = S_PAR;
      S_STOP: begin
        if (!bit_tick_s)       state_nx_s = S_STOP;
        else if (!last_byte_s) state_nx_s = S_START;
        else if (!empty_r)     state_nx_s = S_LOAD;
        else                   state_nx_s = S_IDLE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Bit index for the coming cycle; restarts at 0 outside DATA
  always_comb begin
    bit_idx_nx_s = 3'd0;
    case (state_r)
      S_DATA:  if (bit_tick_s) bit_idx_nx_s = bit_idx_r + 3'd1; else bit_idx_nx_s = bit_idx_r;
      default: bit_idx_nx_s = 3'd0;
    endcase
  end

  // Bit timer, bit/byte indices and frame shift register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baud_cnt_r <= BAUD_W'(0);
      bit_idx_r  <= 3'd0;
      byte_idx_r <= BIDX_W'(0);
      frame_r    <= FRAME_W'(0);
    end else begin
      bit_idx_r <= bit_idx_nx_s;
      if ((state_r == S_IDLE) || (state_r == S_LOAD) || bit_tick_s) begin
        baud_cnt_r <= BAUD_W'(0);
      end else begin
        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
      end
      if (state_r == S_LOAD) begin
        frame_r    <= fifo_mem_r[rd_ptr_r];
        byte_idx_r <= BIDX_W'(0);
      end else if (advance_s) begin
        frame_r    <= frame_r << 4'd8;
        byte_idx_r <= byte_idx_r + BIDX_W'(1);
      end
    end
  end

  // Line level for the state being entered, so s_out can be registered without lag
  always_comb begin
    line_nx_s = 1'b1;
    case (state_nx_s)
      S_START: line_nx_s = 1'b0;
      S_DATA:  line_nx_s = cur_byte_s[bit_idx_nx_s];
      S_PAR:   line_nx_s = parity_of(cur_byte_s);
      default: line_nx_s = 1'b1;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_out_r    <= 1'b1;
      busy_r     <= 1'b0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      s_out_r    <= line_nx_s;
      busy_r     <= (state_nx_s != S_IDLE);
      empty_r    <= (count_nx_s == CNT_W'(0));
      full_r     <= (count_nx_s == CNT_W'(DEPTH));
      overflow_r <= overflow_r | (wr & full_r);
    end
  end

  assign s_out    = s_out_r;
  assign busy     = busy_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three instances cover the base, even-parity and
// wide odd-parity configurations with BAUD_DIV=4 so each bit lasts four clocks.
module tb_uart_frame_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
  logic [15:0] d0 = 16'h0000, d1 = 16'h0000;
  logic [23:0] d2 = 24'h000000;
  logic        so0, busy0, empty0, full0, ovf0;
  logic        so1, busy1, empty1, full1, ovf1;
  logic        so2, busy2, empty2, full2, ovf2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic busy0_q = 1'b0;

  uart_frame_tx #(.BAUD_DIV(4), .NBYTES(2), .DEPTH(4), .PARITY(0), .TERM_EN(1), .TERM_BYTE(8'h0A)) dut0 (
    .clock(clock), .reset(reset), .i_data(d0), .wr(wr0), .s_out(so0),
    .busy(busy0), .empty(empty0), .full(full0), .overflow(ovf0));

  uart_frame_tx #(.BAUD_DIV(4), .NBYTES(2), .DEPTH(4), .PARITY(1), .TERM_EN(0), .TERM_BYTE(8'h0A)) dut1 (
    .clock(clock), .reset(reset), .i_data(d1), .wr(wr1), .s_out(so1),
    .busy(busy1), .empty(empty1), .full(full1), .overflow(ovf1));

  uart_frame_tx #(.BAUD_DIV(4), .NBYTES(3), .DEPTH(4), .PARITY(2), .TERM_EN(1), .TERM_BYTE(8'h0A)) dut2 (
    .clock(clock), .reset(reset), .i_data(d2), .wr(wr2), .s_out(so2),
    .busy(busy2), .empty(empty2), .full(full2), .overflow(ovf2));

  always #5 clock = ~clock;

  // Cycle stamps of busy0 edges, sampled on the falling clock edge
  always @(negedge clock) begin
    cyc     <= cyc + 1;
    busy0_q <= busy0;
    if (busy0 && !busy0_q) rise_cyc <= cyc;
    if (!busy0 && busy0_q) fall_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    case (sel)
      0:       return so0;
      1:       return so1;
      default: return so2;
    endcase
  endfunction

  task automatic write0(input logic [15:0] d);
    d0 = d; wr0 = 1'b1;
    @(posedge clock); #1 wr0 = 1'b0;
  endtask

  task automatic write1(input logic [15:0] d);
    d1 = d; wr1 = 1'b1;
    @(posedge clock); #1 wr1 = 1'b0;
  endtask

  task automatic write2(input logic [23:0] d);
    d2 = d; wr2 = 1'b1;
    @(posedge clock); #1 wr2 = 1'b0;
  endtask

  // Wait for a start bit, then sample each bit 'mid' cycles after detection.
  // gap = idle-high falling-edge samples seen before the start bit.
  task automatic expect_char(input int sel, input string tag, input logic [7:0] exp_b,
                             input bit has_par, input logic exp_p, input int exp_gap, input int mid);
    int         gap;
    bit         found;
    logic [7:0] b;
    gap = 0; found = 1'b0; b = 8'h00;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clock);
      if (line_of(sel) == 1'b0) found = 1'b1; else gap++;
    end
    chk({tag, " start seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      repeat (mid) @(negedge clock);
      chk({tag, " start bit"}, {31'd0, line_of(sel)}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clock);
        b[i] = line_of(sel);
      end
      chk({tag, " data"}, {24'd0, b}, {24'd0, exp_b});
      if (has_par) begin
        repeat (4) @(negedge clock);
        chk({tag, " parity"}, {31'd0, line_of(sel)}, {31'd0, exp_p});
      end
      repeat (4) @(negedge clock);
      chk({tag, " stop"}, {31'd0, line_of(sel)}, 32'd1);
      chk({tag, " gap"}, gap, exp_gap);
    end
  endtask

  task automatic wait_idle0(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (!busy0) done = 1'b1;
    end
    chk({tag, " busy falls"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lows;
    logic [7:0] bytes_b2b [9];
    logic [7:0] exp_b;
    int exp_gap;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst s_out", {31'd0, so0}, 32'd1);
    chk("rst busy", {31'd0, busy0}, 32'd0);
    chk("rst empty", {31'd0, empty0}, 32'd1);
    chk("rst full", {31'd0, full0}, 32'd0);
    chk("rst overflow", {31'd0, ovf0}, 32'd0);
    chk("rst s_out dut2", {31'd0, so2}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single frame: A5, C3, terminator 0A; latency and busy length
    write0(16'hA5C3);
    @(negedge clock);
    chk("enq empty", {31'd0, empty0}, 32'd0);
    chk("enq busy", {31'd0, busy0}, 32'd0);
    @(negedge clock);
    chk("load busy", {31'd0, busy0}, 32'd1);
    chk("load s_out", {31'd0, so0}, 32'd1);
    expect_char(0, "base b0", 8'hA5, 1'b0, 1'b0, 0, 2);
    expect_char(0, "base b1", 8'hC3, 1'b0, 1'b0, 1, 2);
    expect_char(0, "base b2", 8'h0A, 1'b0, 1'b0, 1, 2);
    wait_idle0("base");
    @(negedge clock);
    chk("base busy length", fall_cyc - rise_cyc, 32'd121);
    chk("base empty after", {31'd0, empty0}, 32'd1);

    // Even parity: 07 -> 1, A5 -> 0
    write1(16'h07A5);
    expect_char(1, "even b0", 8'h07, 1'b1, 1'b1, 2, 2);
    expect_char(1, "even b1", 8'hA5, 1'b1, 1'b0, 1, 2);

    // Wide odd parity: 12 -> 1, 34 -> 0, 56 -> 1, 0A -> 1
    write2(24'h123456);
    expect_char(2, "wide b0", 8'h12, 1'b1, 1'b1, 2, 2);
    expect_char(2, "wide b1", 8'h34, 1'b1, 1'b0, 1, 2);
    expect_char(2, "wide b2", 8'h56, 1'b1, 1'b1, 1, 2);
    expect_char(2, "wide b3", 8'h0A, 1'b1, 1'b1, 1, 2);
    repeat (10) @(negedge clock);
    chk("wide idle", {31'd0, busy2}, 32'd0);

    // Back-to-back: three writes on consecutive cycles, one LOAD cycle between frames
    write0(16'h1122);
    write0(16'h3344);
    write0(16'h5566);
    bytes_b2b = '{8'h11, 8'h22, 8'h0A, 8'h33, 8'h44, 8'h0A, 8'h55, 8'h66, 8'h0A};
    for (int j = 0; j < 9; j++) begin
      exp_gap = (j == 0) ? 0 : ((j % 3 == 0) ? 2 : 1);
      expect_char(0, $sformatf("b2b c%0d", j), bytes_b2b[j], 1'b0, 1'b0, exp_gap, 2);
    end
    wait_idle0("b2b");
    chk("b2b overflow", {31'd0, ovf0}, 32'd0);

    // Overflow: six writes from idle; the first is popped, so the 5th fills and the 6th drops
    write0(16'h1121);
    write0(16'h1222);
    write0(16'h1323);
    write0(16'h1424);
    chk("ovf full after 4", {31'd0, full0}, 32'd0);
    write0(16'h1525);
    chk("ovf full after 5", {31'd0, full0}, 32'd1);
    chk("ovf flag after 5", {31'd0, ovf0}, 32'd0);
    write0(16'h1626);
    chk("ovf flag after 6", {31'd0, ovf0}, 32'd1);
    // First start bit is already in its last cycle here, so sample late for that character
    for (int j = 0; j < 15; j++) begin
      exp_b   = (j % 3 == 0) ? 8'h10 + 8'(j / 3 + 1) :
                (j % 3 == 1) ? 8'h20 + 8'(j / 3 + 1) : 8'h0A;
      exp_gap = (j < 2) ? 0 : ((j % 3 == 0) ? 2 : 1);
      expect_char(0, $sformatf("ovf c%0d", j), exp_b, 1'b0, 1'b0, exp_gap, (j == 0) ? 0 : 2);
    end
    wait_idle0("ovf");
    chk("ovf empty", {31'd0, empty0}, 32'd1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!so0) lows++;
    end
    chk("ovf no 6th frame", lows, 32'd0);
    chk("ovf sticky", {31'd0, ovf0}, 32'd1);

    // Reset during DATA of byte 1
    write0(16'hA5C3);
    write0(16'h0F0F);
    expect_char(0, "mid b0", 8'hA5, 1'b0, 1'b0, 1, 2);
    repeat (16) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid rst s_out", {31'd0, so0}, 32'd1);
    chk("mid rst busy", {31'd0, busy0}, 32'd0);
    chk("mid rst empty", {31'd0, empty0}, 32'd1);
    chk("mid rst overflow", {31'd0, ovf0}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!so0 || busy0) lows++;
    end
    chk("mid no resume", lows, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
